// File: rtl/led_display_package.sv
// Shared types for the HUB75 LED panel driver.
//   pxl_col_t   : one half-panel row of pixels, one bit per column per colour
//   drv_state_t : row driver FSM states
package led_display_package;

   localparam int unsigned PXL_COLS = 64;

   typedef struct packed {
      logic [PXL_COLS-1:0] blue;
      logic [PXL_COLS-1:0] green;
      logic [PXL_COLS-1:0] red;
   } pxl_col_t;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH,
      DISPLAY
   } drv_state_t;

endpackage

// File: rtl/hub75_col_shifter.sv
// Column shifter: holds the captured top/bottom row and presents one column
// per shift, highest column index first, zeros shifted in behind.
//   bclk, n_reset : clock, async active-low reset
//   i_load        : capture i_top/i_bot
//   i_shift       : advance to the next lower column
//   o_rgb_top/bot : {blue, green, red} of the current column (register bits)
module hub75_col_shifter
   import led_display_package::*;
#(
   parameter int unsigned NUM_COLS = 64
) (
   input  logic       bclk,
   input  logic       n_reset,
   input  logic       i_load,
   input  logic       i_shift,
   input  pxl_col_t   i_top,
   input  pxl_col_t   i_bot,
   output logic [2:0] o_rgb_top,
   output logic [2:0] o_rgb_bot
);

   // index 0 = red, 1 = green, 2 = blue
   logic [2:0][NUM_COLS-1:0] r_top;
   logic [2:0][NUM_COLS-1:0] r_bot;

   // Left shift so column NUM_COLS-1 is presented first; the register drains
   // to zero after the last column, which blanks rgb outside SHIFT.
   always_ff @(posedge bclk or negedge n_reset) begin
      if (!n_reset) begin
         r_top <= '0;
         r_bot <= '0;
      end else if (i_load) begin
         r_top <= {i_top.blue[NUM_COLS-1:0], i_top.green[NUM_COLS-1:0], i_top.red[NUM_COLS-1:0]};
         r_bot <= {i_bot.blue[NUM_COLS-1:0], i_bot.green[NUM_COLS-1:0], i_bot.red[NUM_COLS-1:0]};
      end else if (i_shift) begin
         for (int c = 0; c < 3; c++) begin
            r_top[c] <= {r_top[c][NUM_COLS-2:0], 1'b0};
            r_bot[c] <= {r_bot[c][NUM_COLS-2:0], 1'b0};
         end
      end
   end

   assign o_rgb_top = {r_top[2][NUM_COLS-1], r_top[1][NUM_COLS-1], r_top[0][NUM_COLS-1]};
   assign o_rgb_bot = {r_bot[2][NUM_COLS-1], r_bot[1][NUM_COLS-1], r_bot[0][NUM_COLS-1]};

endmodule

// File: rtl/hub75_row_driver.sv
// HUB75 row driver: accepts one row (address + top/bottom pixels), shifts it
// into the panel, latches it and displays it for ON_CYCLES bclk cycles.
//   bclk, n_reset        : clock, async active-low reset
//   brightness           : (HUB75_DIM_EN only) oe-low time = ON_CYCLES*brightness/256
//   row_valid/row_ready  : row load handshake, ready only in IDLE
//   row_addr/top/bot     : row to display
//   sclk, rgb_top/bot    : panel shift clock and data
//   addr_out, le, oe     : panel row address, latch enable, output enable (low)
//   row_done             : one-cycle pulse when the display period ends
// Optional macro: HUB75_DIM_EN enables the brightness input.
module hub75_row_driver
   import led_display_package::*;
#(
   parameter int unsigned NUM_COLS  = 64,
   parameter int unsigned NUM_ROWS  = 32,
   parameter int unsigned ON_CYCLES = 256
) (
   input  logic                              bclk,
   input  logic                              n_reset,
`ifdef HUB75_DIM_EN
   input  logic [7:0]                        brightness,
`endif
   input  logic                              row_valid,
   output logic                              row_ready,
   input  logic [$clog2(NUM_ROWS/2)-1:0]     row_addr,
   input  pxl_col_t                          row_top,
   input  pxl_col_t                          row_bot,
   output logic                              sclk,
   output logic [2:0]                        rgb_top,
   output logic [2:0]                        rgb_bot,
   output logic [$clog2(NUM_ROWS/2)-1:0]     addr_out,
   output logic                              le,
   output logic                              oe,
   output logic                              row_done
);

   localparam int unsigned ADDR_W = $clog2(NUM_ROWS/2);
   localparam int unsigned CNT_W  = $clog2(NUM_COLS) + 1;
   localparam int unsigned DSP_W  = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(2*NUM_COLS - 1);
   localparam logic [DSP_W-1:0] LAST_DSP   = DSP_W'(ON_CYCLES - 1);

   drv_state_t        r_state;
   logic [CNT_W-1:0]  r_col_cnt;
   logic [DSP_W-1:0]  r_dsp_cnt;
   logic [ADDR_W-1:0] r_addr;

   logic              w_load;
   logic              w_shift;
   logic [31:0]       w_on_time;
   logic              w_oe_next_on;

   // Number of DISPLAY cycles with oe low.
`ifdef HUB75_DIM_EN
   logic [39:0] w_on_prod;
   assign w_on_prod = 40'(ON_CYCLES) * 40'(brightness);
   assign w_on_time = 32'(w_on_prod >> 8);
`else
   assign w_on_time = 32'(ON_CYCLES);
`endif

   assign w_oe_next_on = (32'(r_dsp_cnt) + 32'd1) < w_on_time;

   // row_ready is 1 throughout IDLE, so row_valid alone qualifies the load.
   assign w_load  = (r_state == IDLE) && row_valid;
   // Advance the column as each sclk high phase ends.
   assign w_shift = (r_state == SHIFT) && r_col_cnt[0];

   hub75_col_shifter #(
      .NUM_COLS (NUM_COLS)
   ) u_col_shifter (
      .bclk      (bclk),
      .n_reset   (n_reset),
      .i_load    (w_load),
      .i_shift   (w_shift),
      .i_top     (row_top),
      .i_bot     (row_bot),
      .o_rgb_top (rgb_top),
      .o_rgb_bot (rgb_bot)
   );

   // Row sequencing FSM; outputs are registered for the state being entered.
   always_ff @(posedge bclk or negedge n_reset) begin
      if (!n_reset) begin
         r_state   <= IDLE;
         r_col_cnt <= '0;
         r_dsp_cnt <= '0;
         r_addr    <= '0;
         row_ready <= 1'b1;
         sclk      <= 1'b0;
         addr_out  <= '0;
         le        <= 1'b0;
         oe        <= 1'b1;
         row_done  <= 1'b0;
      end else begin
         row_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (row_valid) begin
                  r_addr    <= row_addr;
                  r_col_cnt <= '0;
                  row_ready <= 1'b0;
                  sclk      <= 1'b0;
                  r_state   <= SHIFT;
               end
            end
            SHIFT: begin
               // Even phase: data set up with sclk low; odd phase: sclk high.
               if (!r_col_cnt[0]) begin
                  sclk      <= 1'b1;
                  r_col_cnt <= r_col_cnt + CNT_W'(1);
               end else begin
                  sclk <= 1'b0;
                  if (r_col_cnt == LAST_PHASE) begin
                     r_col_cnt <= '0;
                     le        <= 1'b1;
                     addr_out  <= r_addr;
                     r_state   <= LATCH;
                  end else begin
                     r_col_cnt <= r_col_cnt + CNT_W'(1);
                  end
               end
            end
            LATCH: begin
               if (r_col_cnt[0]) begin
                  r_col_cnt <= '0;
                  r_dsp_cnt <= '0;
                  le        <= 1'b0;
                  oe        <= (w_on_time == 32'd0);
                  r_state   <= DISPLAY;
               end else begin
                  r_col_cnt <= r_col_cnt + CNT_W'(1);
               end
            end
            DISPLAY: begin
               if (r_dsp_cnt == LAST_DSP) begin
                  r_dsp_cnt <= '0;
                  oe        <= 1'b1;
                  row_done  <= 1'b1;
                  row_ready <= 1'b1;
                  r_state   <= IDLE;
               end else begin
                  r_dsp_cnt <= r_dsp_cnt + DSP_W'(1);
                  oe        <= !w_oe_next_on;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hub75_row_driver.sv
// Testbench for hub75_row_driver: directed row sequences with random pixel
// data, a cycle timeline derived from the row protocol, and a panel receiver
// model that shifts on sclk rising edges and latches on le.
module tb_hub75_row_driver;
   import led_display_package::*;

   localparam int NC      = 64;
   localparam int ONC     = 256;
   localparam int ROW_CYC = 2*NC + 2 + ONC + 1;

   logic       bclk      = 1'b0;
   logic       n_reset   = 1'b0;
   logic       row_valid = 1'b0;
   logic [3:0] row_addr  = 4'h0;
   pxl_col_t   row_top   = '0;
   pxl_col_t   row_bot   = '0;
`ifdef HUB75_DIM_EN
   logic [7:0] brightness = 8'hFF;
`endif
   logic       row_ready, sclk, le, oe, row_done;
   logic [2:0] rgb_top, rgb_bot;
   logic [3:0] addr_out;
   logic [14:0] w_obs;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [3:0] last_addr = 4'h0;

   hub75_row_driver #(.NUM_COLS(NC), .NUM_ROWS(32), .ON_CYCLES(ONC)) dut (
      .bclk      (bclk),
      .n_reset   (n_reset),
`ifdef HUB75_DIM_EN
      .brightness(brightness),
`endif
      .row_valid (row_valid),
      .row_ready (row_ready),
      .row_addr  (row_addr),
      .row_top   (row_top),
      .row_bot   (row_bot),
      .sclk      (sclk),
      .rgb_top   (rgb_top),
      .rgb_bot   (rgb_bot),
      .addr_out  (addr_out),
      .le        (le),
      .oe        (oe),
      .row_done  (row_done)
   );

   always #5 bclk = ~bclk;
   always @(posedge bclk) cyc <= cyc + 1;

   assign w_obs = {row_ready, sclk, rgb_top, rgb_bot, addr_out, le, oe, row_done};

   // Panel receiver model: left-shifting shift register, latched on le.
   logic [2:0][NC-1:0] rx_sh_top = '0, rx_sh_bot = '0, rx_lat_top = '0, rx_lat_bot = '0;
   logic [3:0] rx_addr   = 4'h0;
   logic       prev_sclk = 1'b0, prev_le = 1'b0;
   int         le_pulses = 0;

   always @(negedge bclk) begin
      if (sclk && !prev_sclk)
         for (int c = 0; c < 3; c++) begin
            rx_sh_top[c] = {rx_sh_top[c][NC-2:0], rgb_top[c]};
            rx_sh_bot[c] = {rx_sh_bot[c][NC-2:0], rgb_bot[c]};
         end
      if (le && !prev_le) le_pulses = le_pulses + 1;
      if (le) begin
         rx_lat_top = rx_sh_top;
         rx_lat_bot = rx_sh_bot;
         rx_addr    = addr_out;
      end
      prev_sclk = sclk;
      prev_le   = le;
   end

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] ev(input logic rdy, input logic s, input logic [2:0] rt,
                                      input logic [2:0] rb, input logic [3:0] ad,
                                      input logic l, input logic o, input logic d);
      return {rdy, s, rt, rb, ad, l, o, d};
   endfunction

   function automatic pxl_col_t rnd_pxl();
      pxl_col_t p;
      p.red   = {$urandom(), $urandom()};
      p.green = {$urandom(), $urandom()};
      p.blue  = {$urandom(), $urandom()};
      return p;
   endfunction

   function automatic int on_time();
`ifdef HUB75_DIM_EN
      return (ONC * int'(brightness)) / 256;
`else
      return ONC;
`endif
   endfunction

   int done_cyc = 0;

   // Load one row, then check every cycle until the row_done cycle.
   task automatic run_row(input logic [3:0] a, input pxl_col_t t, input pxl_col_t b, input bit hold);
      int waited, col, j, on_t;
      logic [2:0] et, eb;
      logic s, l, o;
      logic [3:0] ad;
      on_t = on_time();
      row_addr = a; row_top = t; row_bot = b; row_valid = 1'b1;
      waited = 0;
      while (row_ready !== 1'b1 && waited < 1000) begin
         @(posedge bclk); #1; waited++;
      end
      chk("accept_wait", 192'(waited < 1000), 192'(1));
      @(posedge bclk); #1;
      // Anything presented outside IDLE must be ignored.
      row_addr = 4'($urandom()); row_top = rnd_pxl(); row_bot = rnd_pxl(); row_valid = hold;
      for (int k = 1; k <= ROW_CYC; k++) begin
         et = 3'b000; eb = 3'b000; s = 1'b0; l = 1'b0; o = 1'b1;
         ad = (k <= 2*NC) ? last_addr : a;
         if (k <= 2*NC) begin
            col = NC - 1 - (k - 1) / 2;
            et  = {t.blue[col], t.green[col], t.red[col]};
            eb  = {b.blue[col], b.green[col], b.red[col]};
            s   = ((k - 1) % 2) == 1;
         end else if (k <= 2*NC + 2) begin
            l = 1'b1;
         end else if (k < ROW_CYC) begin
            j = k - (2*NC + 3);
            o = !(j < on_t);
         end
         chk($sformatf("row%0h k=%0d", a, k), 192'(w_obs),
             192'(ev(k == ROW_CYC, s, et, eb, ad, l, o, k == ROW_CYC)));
         if (k < ROW_CYC) begin
            @(posedge bclk); #1;
         end
      end
      done_cyc  = cyc;
      last_addr = a;
      chk($sformatf("rx_addr%0h", a), 192'(rx_addr), 192'(a));
      chk($sformatf("rx_top%0h", a), 192'(rx_lat_top), {t.blue, t.green, t.red});
      chk($sformatf("rx_bot%0h", a), 192'(rx_lat_bot), {b.blue, b.green, b.red});
   endtask

   initial begin
      #200_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      pxl_col_t   t, b;
      int         d0, d1, le_before;
      logic [14:0] rst_vec;
      rst_vec = ev(1'b1, 1'b0, 3'b0, 3'b0, 4'h0, 1'b0, 1'b1, 1'b0);

      // Reset state
      repeat (3) @(posedge bclk);
      #1 chk("reset_hold", 192'(w_obs), 192'(rst_vec));
      n_reset = 1'b1;
      repeat (2) @(posedge bclk);
      #1 chk("idle_after_reset", 192'(w_obs), 192'(rst_vec));

      // Single-bit edge columns in red
      t = '0; b = '0;
      t.red = 64'h8000_0000_0000_0001;
      run_row(4'h5, t, b, 1'b0);
      chk("le_pulses_1", 192'(le_pulses), 192'(1));

      // Alternating pattern loopback
      t.red = {16{4'hA}}; t.green = {16{4'hA}}; t.blue = {16{4'hA}};
      run_row(4'h5, t, t, 1'b0);

      // Back-to-back rows with row_valid held high
      run_row(4'h0, rnd_pxl(), rnd_pxl(), 1'b1);
      d0 = done_cyc;
      run_row(4'h1, rnd_pxl(), rnd_pxl(), 1'b1);
      d1 = done_cyc;
      chk("period_0_1", 192'(d1 - d0), 192'(ROW_CYC));
      run_row(4'h2, rnd_pxl(), rnd_pxl(), 1'b1);
      row_valid = 1'b0;
      chk("period_1_2", 192'(done_cyc - d1), 192'(ROW_CYC));
      @(posedge bclk); #1;
      chk("idle_no_valid", 192'(w_obs), 192'(ev(1'b1, 1'b0, 3'b0, 3'b0, 4'h2, 1'b0, 1'b1, 1'b0)));

      // Reset during the column-20 sclk high phase
      le_before = le_pulses;
      row_addr = 4'h9; row_top = rnd_pxl(); row_bot = rnd_pxl(); row_valid = 1'b1;
      @(posedge bclk); #1;
      row_valid = 1'b0;
      repeat (2*(NC - 1 - 20) + 1) @(posedge bclk);
      #1 chk("sclk_before_reset", 192'(sclk), 192'(1));
      #2 n_reset = 1'b0;
      #1 chk("reset_async", 192'(w_obs), 192'(rst_vec));
      repeat (3) @(posedge bclk);
      #1 n_reset = 1'b1;
      @(posedge bclk); #1;
      chk("ready_after_abort", 192'(w_obs), 192'(rst_vec));
      chk("no_le_on_abort", 192'(le_pulses), 192'(le_before));
      last_addr = 4'h0;
      run_row(4'hC, rnd_pxl(), rnd_pxl(), 1'b0);

      // Random rows
      for (int r = 0; r < 2; r++)
         run_row(4'($urandom()), rnd_pxl(), rnd_pxl(), 1'b0);

`ifdef HUB75_DIM_EN
      brightness = 8'h40;
      run_row(4'h3, rnd_pxl(), rnd_pxl(), 1'b0);
      brightness = 8'h00;
      run_row(4'h4, rnd_pxl(), rnd_pxl(), 1'b0);
      brightness = 8'($urandom());
      run_row(4'h6, rnd_pxl(), rnd_pxl(), 1'b0);
      brightness = 8'hFF;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hub75_row_driver.md
HUB75_ROW_DRIVER -- requirements
Module: hub75_row_driver

Interface
REQ-001 SHALL have parameter NUM_COLS, default 64: pixels per row per half-panel.
REQ-002 SHALL have parameter NUM_ROWS, default 32: panel rows; address width is clog2(NUM_ROWS/2) = 4.
REQ-003 SHALL have parameter ON_CYCLES, default 256: bclk cycles with OE active per displayed row.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- bclk, in, 1: clock.
- n_reset, in, 1: reset, asynchronous, active-low.
- row_valid, in, 1: row load request.
- row_ready, out, 1: driver can accept a row.
- row_addr, in, 4: row address.
- row_top, in, pxl_col_t: top-half pixels.
- row_bot, in, pxl_col_t: bottom-half pixels.
- sclk, out, 1: panel shift clock.
- rgb_top, out, 3: {blue, green, red}, top half.
- rgb_bot, out, 3: {blue, green, red}, bottom half.
- addr_out, out, 4: panel row address.
- le, out, 1: latch enable, active-high.
- oe, out, 1: output enable, active-low.
- row_done, out, 1: one-cycle pulse at end of display.

Function
REQ-005 SHALL implement FSM states IDLE, SHIFT, LATCH, DISPLAY.
REQ-006 IDLE: row_ready=1; row_valid&row_ready in the same cycle captures row_addr/row_top/row_bot into internal registers and moves to SHIFT next cycle.
REQ-007 row_ready SHALL be 0 in every state except IDLE; row inputs SHALL be ignored outside IDLE.
REQ-008 SHIFT: per column, SHALL drive rgb_top/rgb_bot with sclk=0 for one cycle, then sclk=1 for one cycle; this is 2*NUM_COLS cycles total.
REQ-009 Column order SHALL be index NUM_COLS-1 first, down to index 0 last, so a left-shifting receiver holds the captured vector unchanged.
REQ-010 Column counter SHALL be clog2(NUM_COLS)+1 bits wide and SHALL leave SHIFT when the column-0 sclk high phase ends.
REQ-011 LATCH: sclk=0, rgb outputs=0, addr_out=captured address, le=1 for exactly 2 cycles, then DISPLAY.
REQ-012 DISPLAY: oe=0 for exactly ON_CYCLES cycles; le=0; addr_out stays stable.
REQ-013 Leaving DISPLAY: row_done=1 for 1 cycle and return to IDLE; row_ready=1 in that same cycle.
REQ-014 oe SHALL be 1 in all states except DISPLAY; addr_out SHALL change only in LATCH, and only while oe=1.
REQ-015 A back-to-back row_valid held high SHALL be accepted in the first IDLE cycle after row_done, giving a row period of 2*NUM_COLS+2+ON_CYCLES+1 cycles.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 On n_reset=0, immediately: state=IDLE, sclk=0, rgb_top=rgb_bot=0, addr_out=0, le=0, oe=1, row_done=0, counters=0, capture registers=0.
REQ-018 Reset mid-SHIFT/LATCH/DISPLAY SHALL abort the row with no partial latch; after release the FSM starts in IDLE with row_ready=1.

Configuration
REQ-019 Macro HUB75_DIM_EN, when defined, SHALL add input brightness[7:0] and make the DISPLAY oe=0 time (ON_CYCLES*brightness)>>8 cycles, followed by oe=1 for the rest of ON_CYCLES; brightness=0 SHALL give oe=1 throughout.
REQ-020 Without HUB75_DIM_EN there SHALL be no brightness port and oe=0 SHALL last the full ON_CYCLES.
REQ-021 The total DISPLAY duration SHALL be ON_CYCLES in both configurations.

Structure
REQ-022 pxl_col_t and the FSM state enum SHALL live in led_display_package.
REQ-023 The column shifter SHALL be sub-module hub75_col_shifter (load, shift, 3-bit top/bottom outputs); FSM and counters stay in the top level.

Verification
REQ-024 Reset release, then row_addr=4'h5, row_top.red=64'h8000_0000_0000_0001, all other data 0 -> the first shifted rgb_top=3'b001 and the last shifted rgb_top=3'b001, with 0 in between; le pulse of 2 cycles with addr_out=4'h5; then oe=0 for 256 cycles and one row_done pulse.
REQ-025 Loopback to the panel receiver model with row_top=row_bot=alternating 0xAA.. in all colours -> the receiver reports Addr 5 and vectors identical to the inputs.
REQ-026 row_valid held high for 3 rows, addresses 0,1,2 -> row_ready high only in IDLE; the row_done pulses are 387 cycles apart.
REQ-027 n_reset asserted at column 20 of SHIFT -> oe=1, le=0, sclk=0 immediately; no le pulse; the next row completes normally.
REQ-028 With HUB75_DIM_EN and brightness=8'h40 -> oe=0 for 64 cycles, then oe=1 for 192 cycles; with brightness=0 -> oe never goes low.
